// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin arbiter sharing one divider among NREQ requesters
module div_share_arbiter #(
    parameter int W       = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_dividend,
    input  logic [NREQ*W-1:0] req_divisor,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_quotient,
    output logic [W-1:0]      rsp_remainder,
    output logic              rsp_dbz,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              div_start,
    output logic [W-1:0]      div_dividend,
    output logic [W-1:0]      div_divisor,
    input  logic [W-1:0]      div_quotient,
    input  logic [W-1:0]      div_remainder,
    input  logic              div_done,
    input  logic              div_by_zero
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  cur_port;
    logic [PW-1:0]  grant_idx;
    logic [PW-1:0]  grant_nxt_ptr;
    logic           grant_found;
    logic [7:0]     wait_cnt;
    logic           timeout_hit;

    // First valid port at or above rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = PW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign grant_nxt_ptr = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    assign timeout_hit   = (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        div_start = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (div_done || timeout_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[cur_port] = 1'b1;
                if (rsp_ready[cur_port]) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, wait counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            cur_port      <= '0;
            wait_cnt      <= '0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        cur_port     <= grant_idx;
                        rr_ptr       <= grant_nxt_ptr;
                        div_dividend <= req_dividend[int'(grant_idx)*W +: W];
                        div_divisor  <= req_divisor[int'(grant_idx)*W +: W];
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (div_done) begin
                        if (div_by_zero) begin
                            rsp_quotient  <= '1;
                            rsp_remainder <= div_dividend;
                            rsp_dbz       <= 1'b1;
                        end else begin
                            rsp_quotient  <= div_quotient;
                            rsp_remainder <= div_remainder;
                        end
                    end else if (timeout_hit) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_timeout   <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[cur_port]) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_dbz       <= 1'b0;
                        rsp_timeout   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - randomized self-checking bench for div_share_arbiter
module tb_div_share_arbiter;

    localparam int W       = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*W-1:0] req_dividend, req_divisor;
    logic [W-1:0]      rsp_quotient, rsp_remainder;
    logic              rsp_dbz, rsp_timeout, busy, div_start;
    logic [W-1:0]      div_dividend, div_divisor, div_quotient, div_remainder;
    logic              div_done, div_by_zero;

    always #5 clk = ~clk;

    div_share_arbiter #(.W(W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout), .busy(busy),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_done(div_done), .div_by_zero(div_by_zero)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_rr = 0;
    int          m_port, m_acc, m_rsp_at;
    logic [W-1:0] m_a, m_b, m_q, m_r;
    bit          m_dbz, m_to;
    int          grants[$];
    int          pend_clear = -1;
    bit          auto_refill = 0;
    bit          div_en = 1;
    bit          spur_en = 0;

    // Divider stand-in: done three cycles after it samples start
    logic d1, d2, d3;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= 0; d2 <= 0; d3 <= 0;
            div_done <= 0; div_by_zero <= 0; div_quotient <= '0; div_remainder <= '0;
        end else begin
            d1 <= div_start; d2 <= d1; d3 <= d2;
            if (d3 && div_en) begin
                div_done    <= 1'b1;
                div_by_zero <= (div_divisor == 0);
                div_quotient  <= (div_divisor == 0) ? W'($urandom) : div_dividend / div_divisor;
                div_remainder <= (div_divisor == 0) ? W'($urandom) : div_dividend % div_divisor;
            end else if (spur_en && !m_busy && $urandom_range(3) == 0) begin
                div_done      <= 1'b1;
                div_by_zero   <= 1'($urandom_range(1));
                div_quotient  <= W'($urandom);
                div_remainder <= W'($urandom);
            end else begin
                div_done    <= 1'b0;
                div_by_zero <= 1'($urandom_range(1));
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++)
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    task automatic load(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[p] = 1'b1;
        req_dividend[p*W +: W] = a;
        req_divisor[p*W +: W]  = b;
    endtask

    task automatic load_random(input int p);
        logic [W-1:0] b;
        b = ($urandom_range(7) == 0) ? '0 : W'($urandom);
        load(p, W'($urandom), b);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_div_start"}, div_start, 0);
        check_eq({tag, "_rsp_q"}, rsp_quotient, 0);
        check_eq({tag, "_rsp_r"}, rsp_remainder, 0);
        check_eq({tag, "_rsp_dbz"}, rsp_dbz, 0);
        check_eq({tag, "_rsp_to"}, rsp_timeout, 0);
        check_eq({tag, "_div_a"}, div_dividend, 0);
        check_eq({tag, "_div_b"}, div_divisor, 0);
    endtask

    // One clock: predict the edge from current inputs, then check the post-edge outputs.
    task automatic tick();
        int g;
        bit was_busy, inr;
        logic [NREQ-1:0] er;
        #1;
        was_busy = m_busy;
        g = -1;
        er = '0;
        if (!was_busy) begin
            g = pick(req_valid, m_rr);
            if (g >= 0) er[g] = 1'b1;
        end
        check_eq("req_ready", req_ready, er);
        if (was_busy) begin
            if (cyc >= m_rsp_at && rsp_ready[m_port]) m_busy = 0;
        end else if (g >= 0) begin
            m_a = req_dividend[g*W +: W];
            m_b = req_divisor[g*W +: W];
            m_busy = 1; m_port = g; m_acc = cyc + 1; m_rr = (g + 1) % NREQ;
            grants.push_back(g);
            m_to = !div_en;
            m_dbz = 0;
            if (m_to) begin
                m_q = '0; m_r = '0; m_rsp_at = m_acc + TIMEOUT + 1;
            end else if (m_b == 0) begin
                m_q = '1; m_r = m_a; m_dbz = 1; m_rsp_at = m_acc + 5;
            end else begin
                m_q = m_a / m_b; m_r = m_a % m_b; m_rsp_at = m_acc + 5;
            end
            pend_clear = g;
        end
        @(posedge clk); #1;
        cyc++;
        if (pend_clear >= 0) begin
            req_valid[pend_clear] = 1'b0;
            if (auto_refill) load_random(pend_clear);
            pend_clear = -1;
        end
        @(negedge clk);
        inr = m_busy && (cyc >= m_rsp_at);
        er = '0;
        if (inr) er[m_port] = 1'b1;
        check_eq("rsp_valid", rsp_valid, er);
        check_eq("busy", busy, m_busy);
        check_eq("div_start", div_start, m_busy && cyc == m_acc);
        check_eq("rsp_quotient", rsp_quotient, inr ? m_q : '0);
        check_eq("rsp_remainder", rsp_remainder, inr ? m_r : '0);
        check_eq("rsp_dbz", rsp_dbz, inr ? m_dbz : 1'b0);
        check_eq("rsp_timeout", rsp_timeout, inr ? m_to : 1'b0);
        if (m_busy) begin
            check_eq("div_dividend", div_dividend, m_a);
            check_eq("div_divisor", div_divisor, m_b);
        end
    endtask

    task automatic wait_idle(input int limit);
        tick();
        for (int i = 0; i < limit && m_busy; i++) tick();
        check_eq("idle_bound", busy, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && (req_valid != 0 || m_busy); i++) tick();
        check_eq("drain_bound", busy, 0);
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        req_valid = '0; rsp_ready = '0; req_dividend = '0; req_divisor = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single op on port 0
        rsp_ready = '1;
        load(0, 8'd200, 8'd7);
        wait_idle(40);

        // Divide by zero then a normal op
        load(2, 8'd13, 8'd0);
        wait_idle(40);
        load(2, 8'd9, 8'd3);
        wait_idle(40);
        load(3, 8'd77, 8'd5);
        wait_idle(40);

        // All ports continuously valid: rotation from pointer 0
        grants.delete();
        auto_refill = 1;
        for (int p = 0; p < NREQ; p++) load_random(p);
        for (int i = 0; i < 300 && grants.size() < 5; i++) tick();
        auto_refill = 0;
        drain();
        check_eq("rr_count", grants.size() >= 5, 1);
        for (int i = 0; i < 5 && i < grants.size(); i++) check_eq("rr_order", grants[i], exp_order[i]);

        // Backpressure on port 1 while other ports request
        rsp_ready = '0;
        load(1, 8'd250, 8'd11);
        tick();
        for (int i = 0; i < 40 && !(m_busy && cyc >= m_rsp_at); i++) tick();
        load(0, 8'd40, 8'd6);
        load(3, 8'd99, 8'd10);
        rsp_ready = 4'b1101;
        repeat (10) tick();
        rsp_ready = '1;
        drain();

        // Divider never answers
        div_en = 0;
        load(0, 8'd123, 8'd4);
        wait_idle(60);
        div_en = 1;
        load(1, 8'd64, 8'd8);
        wait_idle(40);

        // Reset while waiting on the divider
        load(3, 8'd50, 8'd5);
        tick();
        for (int i = 0; i < 20 && !(m_busy && cyc == m_acc + 2); i++) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        m_busy = 0; m_rr = 0; pend_clear = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) tick();
        load(1, 8'd100, 8'd9);
        wait_idle(40);

        // Random traffic with backpressure and stray done pulses
        spur_en = 1;
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NREQ; p++)
                if (!req_valid[p] && $urandom_range(2) == 0) load_random(p);
            rsp_ready = NREQ'($urandom);
            tick();
        end
        spur_en = 0;
        rsp_ready = '1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
